mproc_fetch: RTL and testbench

- Instruction-fetch stage between the 128x16 synchronous instruction RAM and the mproc decode/execute stage.
- Owns the program counter and issues one read address per cycle to the RAM.
- Absorbs the RAM's 1-cycle registered read latency.
- Presents instructions to the decoder with a valid/ready handshake, and supports PC redirect (branch/jump) and halt.

---
 rtl/mproc_pkg.sv | 12 +
 rtl/fetch_buf.sv | 53 +++++
 rtl/mproc_fetch.sv | 77 +++++++
 tb/tb_mproc_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mproc_pkg.sv
// Shared widths, reset PC and the fetch-buffer entry layout for the mproc core
// (fetch stage, decode/execute and the mproc_mem top).
package mproc_pkg;
    localparam int DW = 16;
    localparam int PCW = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [DW-1:0]  instr;
        logic [PCW-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} pairs; head is always a
// register so the decoder never sees a combinational path from RAM data.
module fetch_buf
    import mproc_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     din,
    output entry_t     head,
    output logic [1:0] occ
);
    entry_t tail;
    logic   do_pop;

    assign do_pop = pop & (occ != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new entry lands behind whatever remains
                    if (occ == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mproc_fetch.sv
// Instruction-fetch stage: owns the PC, issues one RAM read per cycle, tracks the
// single in-flight read and feeds a 2-entry buffer toward the decoder.
module mproc_fetch #(
    parameter int             DW       = mproc_pkg::DW,
    parameter int             PCW      = mproc_pkg::PCW,
    parameter logic [PCW-1:0] RESET_PC = PCW'(mproc_pkg::RESET_PC),
    parameter int             DEPTH    = 2
) (
    input  logic           clk,
    input  logic           reset,
    output logic [PCW-1:0] mem_addr,
    output logic           mem_rd,
    input  logic [DW-1:0]  mem_data,
    output logic [DW-1:0]  ins,
    output logic [PCW-1:0] ins_pc,
    output logic           ins_valid,
    input  logic           ins_ready,
    input  logic           redirect,
    input  logic [PCW-1:0] redirect_pc,
    input  logic           halt
);
    typedef struct packed {
        logic [DW-1:0]  instr;
        logic [PCW-1:0] pc;
    } entry_t;

    logic [PCW-1:0] pc;
    logic [PCW-1:0] inflight_pc;
    logic           inflight;
    logic [1:0]     occ;
    logic [2:0]     level;
    logic           pop;
    logic           issue;
    logic           push;
    entry_t         din;
    entry_t         head;

    assign ins_valid = (occ != 2'd0);
    assign ins       = head.instr;
    assign ins_pc    = head.pc;
    assign pop       = ins_valid & ins_ready;

    // Entries that will exist after this cycle's pop; a new read may only be
    // issued if its response is guaranteed a slot when it returns.
    assign level = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue = reset & !halt & !redirect & (level < 3'(DEPTH));

    assign mem_rd   = issue;
    assign mem_addr = pc;

    assign push = inflight & !redirect;
    assign din  = '{instr: mem_data, pc: inflight_pc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect)   pc <= redirect_pc;
            else if (issue) pc <= pc + PCW'(1);
        end
    end

    fetch_buf #(.entry_t(entry_t)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .occ   (occ)
    );
endmodule

// File: tb/tb_mproc_fetch.sv
// Directed bench for mproc_fetch with a behavioural 128x16 registered-read RAM.
module tb_mproc_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;

    logic [15:0] ram_img [128];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= ram_img[mem_addr[6:0]];

    mproc_fetch dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt)
    );

    // Hold reset for two edges, release 1ns after an edge: caller is then in cycle 0.
    task automatic start();
        reset = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; halt = 1'b0; redirect = 1'b0; ins_ready = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (ins_valid !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0 || ins !== 16'h0 || ins_pc !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b rd=%b addr=%h ins=%h pc=%h want 0,0,0000,0000,0000",
                     ins_valid, mem_rd, mem_addr, ins, ins_pc);
        end
    endtask

    task automatic test_stream();
        logic [15:0] first4 [4];
        first4[0] = 16'o000100; first4[1] = 16'o001201; first4[2] = 16'o002321; first4[3] = 16'o003432;
        start(); ins_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #2;
            n_cmp++;
            if (mem_addr !== 16'(c) || mem_rd !== 1'b1) begin
                n_err++;
                $display("FAIL stream_fetch c%0d: addr=%h rd=%b want addr=%h rd=1", c, mem_addr, mem_rd, 16'(c));
            end
            n_cmp++;
            if (c < 2) begin
                if (ins_valid !== 1'b0) begin
                    n_err++; $display("FAIL stream_valid c%0d: valid=%b want 0", c, ins_valid);
                end
            end else if (ins_valid !== 1'b1 || ins_pc !== 16'(c-2) ||
                         ins !== ((c < 6) ? first4[c-2] : (16'hA000 | 16'(c-2)))) begin
                n_err++;
                $display("FAIL stream_ins c%0d: valid=%b pc=%h ins=%o want valid=1 pc=%h", c, ins_valid, ins_pc, ins, 16'(c-2));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ea [13];
        logic        er [13];
        int          ep [13];
        ea = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ep = '{-1, -1, 0, 1, 1, 1, 1, 1, 1, 2, 3, 4, 5};
        start();
        for (int c = 0; c < 13; c++) begin
            ins_ready = !(c >= 3 && c <= 7);
            #2;
            n_cmp++;
            if (mem_addr !== ea[c] || mem_rd !== er[c]) begin
                n_err++;
                $display("FAIL bp_fetch c%0d: addr=%h rd=%b want addr=%h rd=%b", c, mem_addr, mem_rd, ea[c], er[c]);
            end
            n_cmp++;
            if (ep[c] < 0 ? (ins_valid !== 1'b0)
                          : (ins_valid !== 1'b1 || ins_pc !== 16'(ep[c]) || ins !== ram_img[7'(ep[c])])) begin
                n_err++;
                $display("FAIL bp_ins c%0d: valid=%b pc=%h ins=%h want pc=%0d (-1=invalid)", c, ins_valid, ins_pc, ins, ep[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [15:0] ea [11];
        logic        er [11];
        int          ep [11];
        ea = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        er = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ep = '{-1, -1, 0, 1, 2, 3, -1, -1, 2, 3, 4};
        start(); ins_ready = 1'b1; redirect_pc = 16'h0002;
        for (int c = 0; c < 11; c++) begin
            redirect = (c == 5);
            #2;
            n_cmp++;
            if (mem_addr !== ea[c] || mem_rd !== er[c]) begin
                n_err++;
                $display("FAIL redir_fetch c%0d: addr=%h rd=%b want addr=%h rd=%b", c, mem_addr, mem_rd, ea[c], er[c]);
            end
            n_cmp++;
            if (ep[c] < 0 ? (ins_valid !== 1'b0)
                          : (ins_valid !== 1'b1 || ins_pc !== 16'(ep[c]) || ins !== ram_img[7'(ep[c])])) begin
                n_err++;
                $display("FAIL redir_ins c%0d: valid=%b pc=%h ins=%h want pc=%0d (-1=invalid)", c, ins_valid, ins_pc, ins, ep[c]);
            end
            @(posedge clk); #1;
        end
        redirect = 1'b0;
    endtask

    task automatic test_halt();
        logic [15:0] ea [12];
        logic        er [12];
        int          ep [12];
        ea = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd5, 16'd6, 16'd7};
        er = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ep = '{-1, -1, 0, 1, 2, 3, -1, -1, -1, -1, 4, 5};
        start(); ins_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            halt = (c >= 4 && c <= 7);
            #2;
            n_cmp++;
            if (mem_addr !== ea[c] || mem_rd !== er[c]) begin
                n_err++;
                $display("FAIL halt_fetch c%0d: addr=%h rd=%b want addr=%h rd=%b", c, mem_addr, mem_rd, ea[c], er[c]);
            end
            n_cmp++;
            if (ep[c] < 0 ? (ins_valid !== 1'b0)
                          : (ins_valid !== 1'b1 || ins_pc !== 16'(ep[c]) || ins !== ram_img[7'(ep[c])])) begin
                n_err++;
                $display("FAIL halt_ins c%0d: valid=%b pc=%h ins=%h want pc=%0d (-1=invalid)", c, ins_valid, ins_pc, ins, ep[c]);
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] ea [7];
        logic        er [7];
        int          ep [7];
        ea = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        er = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ep = '{-1, -1, 0, -1, -1, 65535, 0};
        start(); ins_ready = 1'b1; redirect_pc = 16'hFFFF;
        for (int c = 0; c < 7; c++) begin
            redirect = (c == 2);
            #2;
            n_cmp++;
            if (mem_addr !== ea[c] || mem_rd !== er[c]) begin
                n_err++;
                $display("FAIL wrap_fetch c%0d: addr=%h rd=%b want addr=%h rd=%b", c, mem_addr, mem_rd, ea[c], er[c]);
            end
            n_cmp++;
            if (ep[c] < 0 ? (ins_valid !== 1'b0)
                          : (ins_valid !== 1'b1 || ins_pc !== 16'(ep[c]) || ins !== ram_img[7'(ep[c])])) begin
                n_err++;
                $display("FAIL wrap_ins c%0d: valid=%b pc=%h ins=%h want pc=%0d (-1=invalid)", c, ins_valid, ins_pc, ins, ep[c]);
            end
            @(posedge clk); #1;
        end
        redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        start();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        #1;
        n_cmp++;
        if (ins_valid !== 1'b1 || ins_pc !== 16'h0000 || mem_rd !== 1'b0 || mem_addr !== 16'h0002) begin
            n_err++;
            $display("FAIL areset_pre: valid=%b pc=%h rd=%b addr=%h want 1,0000,0,0002", ins_valid, ins_pc, mem_rd, mem_addr);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (ins_valid !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0000 || ins !== 16'h0 || ins_pc !== 16'h0) begin
            n_err++;
            $display("FAIL areset_now: valid=%b rd=%b addr=%h ins=%h pc=%h want all 0", ins_valid, mem_rd, mem_addr, ins, ins_pc);
        end
        ins_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_cmp++;
            if (mem_addr !== 16'(c) || mem_rd !== 1'b1 || ins_valid !== (c >= 2) ||
                (c >= 2 && ins_pc !== 16'(c-2))) begin
                n_err++;
                $display("FAIL areset_restart c%0d: addr=%h rd=%b valid=%b pc=%h want addr=%h", c, mem_addr, mem_rd, ins_valid, ins_pc, 16'(c));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram_img[i] = 16'hA000 | 16'(i);
        ram_img[0] = 16'o000100;
        ram_img[1] = 16'o001201;
        ram_img[2] = 16'o002321;
        ram_img[3] = 16'o003432;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
